// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Purpose:
//   Instruction sequencer for a small accumulator-style core. Each instruction
//   steps through FETCH -> DECODE -> EXEC and then returns to FETCH.
//   - FETCH latches the program memory word into the instruction register.
//   - DECODE strobes the PC. It selects either increment or branch load,
//     based on the opcode and the zero flag.
//   - EXEC waits while the execution unit stalls. On its final cycle it issues
//     the register-file write and, when requested, updates the zero flag.
//   A HALT opcode parks the sequencer until reset.
//
// Parameters:
//   PROG_MEM_ADDR_WIDTH  program memory address width (branch target width)
//   INSTR_WIDTH          instruction width, at least 4 + PROG_MEM_ADDR_WIDTH
//
// Ports:
//   clk          in   system clock, all state changes on its rising edge
//   reset        in   asynchronous active-low reset
//   instr_in     in   program memory data at the current PC
//   stall        in   execution unit busy, holds EXEC
//   alu_zero     in   ALU zero result, sampled on the last EXEC cycle
//   flag_we      in   request to load zero_flag from alu_zero at end of EXEC
//   ir           out  instruction register
//   pc_enable    out  PC update strobe (DECODE of a non-HALT instruction)
//   pc_branch    out  PC mux select, 1 = load branch_addr, 0 = increment
//   branch_addr  out  branch target, low address bits of ir
//   phase        out  current state: 00 FETCH, 01 DECODE, 10 EXEC, 11 HALT
//   reg_we       out  register file write strobe
//   zero_flag    out  registered zero flag
//   halted       out  high while parked in HALT
// -----------------------------------------------------------------------------
module fetch_sequencer #(
   parameter int PROG_MEM_ADDR_WIDTH = 8,
   parameter int INSTR_WIDTH         = 24
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [INSTR_WIDTH-1:0]         instr_in,
   input  logic                           stall,
   input  logic                           alu_zero,
   input  logic                           flag_we,
   output logic [INSTR_WIDTH-1:0]         ir,
   output logic                           pc_enable,
   output logic                           pc_branch,
   output logic [PROG_MEM_ADDR_WIDTH-1:0] branch_addr,
   output logic [1:0]                     phase,
   output logic                           reg_we,
   output logic                           zero_flag,
   output logic                           halted
);

   // State encoding doubles as the phase output code.
   typedef enum logic [1:0] {
      ST_FETCH  = 2'b00,
      ST_DECODE = 2'b01,
      ST_EXEC   = 2'b10,
      ST_HALT   = 2'b11
   } state_t;

   localparam logic [3:0] OP_JMP  = 4'hC;
   localparam logic [3:0] OP_BNZ  = 4'hD;
   localparam logic [3:0] OP_BZ   = 4'hE;
   localparam logic [3:0] OP_HALT = 4'hF;

   state_t                   state_q, state_d;
   logic [INSTR_WIDTH-1:0]   ir_q, ir_d;
   logic                     zflag_q, zflag_d;
   logic [3:0]               opcode_s;
   logic                     pc_enable_s;
   logic                     pc_branch_s;
   logic                     reg_we_s;

   // True for any control-transfer opcode. These never write the register file.
   function automatic logic is_branch_op(input logic [3:0] op);
      logic res;
      case (op)
         OP_JMP, OP_BNZ, OP_BZ: res = 1'b1;
         default:               res = 1'b0;
      endcase
      return res;
   endfunction

   // Branch decision. The condition uses the flag registered before DECODE,
   // not the live ALU result.
   function automatic logic branch_taken(input logic [3:0] op, input logic zf);
      logic res;
      case (op)
         OP_JMP:  res = 1'b1;
         OP_BZ:   res = zf;
         OP_BNZ:  res = ~zf;
         default: res = 1'b0;
      endcase
      return res;
   endfunction

   assign opcode_s = ir_q[INSTR_WIDTH-1 -: 4];

   // State, instruction register and zero flag. Reset aborts any instruction in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_FETCH;
         ir_q    <= '0;
         zflag_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         zflag_q <= zflag_d;
      end
   end

   // Next-state and strobe logic. EXEC-only inputs are consulted only in EXEC.
   always_comb begin
      state_d     = state_q;
      ir_d        = ir_q;
      zflag_d     = zflag_q;
      pc_enable_s = 1'b0;
      pc_branch_s = 1'b0;
      reg_we_s    = 1'b0;
      case (state_q)
         ST_FETCH: begin
            ir_d    = instr_in;
            state_d = ST_DECODE;
         end
         ST_DECODE: begin
            if (opcode_s == OP_HALT) begin
               state_d = ST_HALT;
            end else begin
               state_d     = ST_EXEC;
               pc_enable_s = 1'b1;
               pc_branch_s = branch_taken(opcode_s, zflag_q);
            end
         end
         ST_EXEC: begin
            if (stall) begin
               state_d = ST_EXEC;
            end else begin
               state_d  = ST_FETCH;
               reg_we_s = ~is_branch_op(opcode_s);
               if (flag_we) begin
                  zflag_d = alu_zero;
               end else begin
                  zflag_d = zflag_q;
               end
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

   assign ir          = ir_q;
   assign branch_addr = ir_q[PROG_MEM_ADDR_WIDTH-1:0];
   assign phase       = state_q;
   assign zero_flag   = zflag_q;
   assign halted      = (state_q == ST_HALT);
   assign pc_enable   = pc_enable_s;
   assign pc_branch   = pc_branch_s;
   assign reg_we      = reg_we_s;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Directed, table-driven bench for fetch_sequencer. Each table row gives the
// inputs for one clock cycle and the outputs expected in that cycle.
// Hand-written sequences cover HALT absorption and reset during a stalled EXEC.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

   logic        clk;
   logic        reset;
   logic [23:0] instr_in;
   logic        stall;
   logic        alu_zero;
   logic        flag_we;
   logic [23:0] ir;
   logic        pc_enable;
   logic        pc_branch;
   logic [7:0]  branch_addr;
   logic [1:0]  phase;
   logic        reg_we;
   logic        zero_flag;
   logic        halted;

   int checks = 0;
   int errors = 0;
   int we_cnt = 0;

   fetch_sequencer #(
      .PROG_MEM_ADDR_WIDTH(8),
      .INSTR_WIDTH(24)
   ) dut (
      .clk(clk),
      .reset(reset),
      .instr_in(instr_in),
      .stall(stall),
      .alu_zero(alu_zero),
      .flag_we(flag_we),
      .ir(ir),
      .pc_enable(pc_enable),
      .pc_branch(pc_branch),
      .branch_addr(branch_addr),
      .phase(phase),
      .reg_we(reg_we),
      .zero_flag(zero_flag),
      .halted(halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count register-file write pulses mid-cycle.
   always @(negedge clk) begin
      if (reg_we === 1'b1) we_cnt++;
   end

   typedef struct {
      logic [23:0] instr;
      logic        stall;
      logic        az;
      logic        fwe;
      logic [1:0]  phase;
      logic        pce;
      logic        pcb;
      logic        rwe;
      logic        hlt;
      logic        zf;
      logic [23:0] ir;
      logic [7:0]  ba;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic [23:0] i_instr, input logic i_stall, input logic i_az,
                      input logic i_fwe, input logic [1:0] e_phase, input logic e_pce,
                      input logic e_pcb, input logic e_rwe, input logic e_hlt,
                      input logic e_zf, input logic [23:0] e_ir, input logic [7:0] e_ba);
      vec_t v;
      v.instr = i_instr; v.stall = i_stall; v.az = i_az; v.fwe = i_fwe;
      v.phase = e_phase; v.pce = e_pce; v.pcb = e_pcb; v.rwe = e_rwe;
      v.hlt = e_hlt; v.zf = e_zf; v.ir = e_ir; v.ba = e_ba;
      tbl.push_back(v);
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp_v);
      end
   endtask

   function automatic logic [63:0] pack_obs();
      return {25'd0, phase, pc_enable, pc_branch, reg_we, halted, zero_flag, ir, branch_addr};
   endfunction

   // Reset the DUT, check the cleared outputs, release at posedge+1 (state FETCH).
   task automatic do_reset();
      reset = 1'b0;
      stall = 1'b0; alu_zero = 1'b0; flag_we = 1'b0; instr_in = 24'h000000;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", pack_obs(), {25'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, 8'h00});
      reset = 1'b1;
   endtask

   initial begin
      // ---------------- vector table ----------------
      //   instr        st    az    fwe   phase  pce   pcb   rwe   hlt   zf    ir           ba
      // plain instruction 000005
      add(24'h000005, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, 8'h00);
      add(24'h000005, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000005, 8'h05);
      add(24'h000005, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000005, 8'h05);
      // ADD setting zero_flag = 1
      add(24'h100000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000005, 8'h05);
      add(24'h100000, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h100000, 8'h00);
      add(24'h100000, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h100000, 8'h00);
      // BZ taken
      add(24'hE0003A, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h100000, 8'h00);
      add(24'hE0003A, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 24'hE0003A, 8'h3A);
      add(24'hE0003A, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'hE0003A, 8'h3A);
      // instruction clearing zero_flag
      add(24'h200000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'hE0003A, 8'h3A);
      add(24'h200000, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 24'h200000, 8'h00);
      add(24'h200000, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 24'h200000, 8'h00);
      // BZ not taken
      add(24'hE0003A, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h200000, 8'h00);
      add(24'hE0003A, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'hE0003A, 8'h3A);
      add(24'hE0003A, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'hE0003A, 8'h3A);
      // BNZ taken (zf = 0)
      add(24'hD00042, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'hE0003A, 8'h3A);
      add(24'hD00042, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'hD00042, 8'h42);
      add(24'hD00042, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'hD00042, 8'h42);
      // JMP with zf = 0; EXEC-only inputs waved during FETCH/DECODE must be ignored
      add(24'hC000FF, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'hD00042, 8'h42);
      add(24'hC000FF, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'hC000FF, 8'hFF);
      add(24'hC000FF, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'hC000FF, 8'hFF);
      // JMP with zf = 1
      add(24'hC000FF, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'hC000FF, 8'hFF);
      add(24'hC000FF, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 24'hC000FF, 8'hFF);
      add(24'hC000FF, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'hC000FF, 8'hFF);
      // BNZ not taken (zf = 1)
      add(24'hD00042, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'hC000FF, 8'hFF);
      add(24'hD00042, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 24'hD00042, 8'h42);
      add(24'hD00042, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'hD00042, 8'h42);
      // ADD stalled four EXEC cycles: write only on the fifth
      add(24'h100007, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'hD00042, 8'h42);
      add(24'h100007, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 24'h100007, 8'h07);
      add(24'h100007, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h100007, 8'h07);
      add(24'h100007, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h100007, 8'h07);
      add(24'h100007, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h100007, 8'h07);
      add(24'h100007, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h100007, 8'h07);
      add(24'h100007, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 24'h100007, 8'h07);
      add(24'h000005, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h100007, 8'h07);

      // ---------------- apply table ----------------
      do_reset();
      for (int i = 0; i < tbl.size(); i++) begin
         instr_in = tbl[i].instr;
         stall    = tbl[i].stall;
         alu_zero = tbl[i].az;
         flag_we  = tbl[i].fwe;
         #4;
         check($sformatf("vec%0d", i), pack_obs(),
               {25'd0, tbl[i].phase, tbl[i].pce, tbl[i].pcb, tbl[i].rwe, tbl[i].hlt,
                tbl[i].zf, tbl[i].ir, tbl[i].ba});
         @(posedge clk);
         #1;
      end

      // ---------------- HALT is absorbing ----------------
      do_reset();
      instr_in = 24'hF00000;
      #4;
      check("halt_fetch_phase", {62'd0, phase}, {62'd0, 2'b00});
      @(posedge clk); #1;
      instr_in = 24'h000005;
      #4;
      check("halt_decode", {61'd0, phase, pc_enable}, {61'd0, 2'b01, 1'b0});
      @(posedge clk); #1;
      for (int k = 0; k < 20; k++) begin
         stall = k[0]; flag_we = 1'b1; alu_zero = 1'b1;
         #4;
         check($sformatf("halt_hold%0d", k),
               {25'd0, phase, pc_enable, pc_branch, reg_we, halted, zero_flag, ir, branch_addr},
               {25'd0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 24'hF00000, 8'h00});
         @(posedge clk); #1;
      end
      reset = 1'b0;
      #1;
      check("halt_reset_clear", {37'd0, phase, halted, ir}, {37'd0, 2'b00, 1'b0, 24'h000000});
      stall = 1'b0; flag_we = 1'b0; alu_zero = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      #4;
      check("halt_release_fetch", {62'd0, phase}, {62'd0, 2'b00});
      @(posedge clk); #1;
      check("halt_release_decode", {38'd0, phase, ir}, {38'd0, 2'b01, 24'h000005});

      // ---------------- reset during stalled EXEC ----------------
      do_reset();
      instr_in = 24'h100000;
      @(posedge clk); #1;                        // DECODE
      @(posedge clk); #1;                        // EXEC: set zero_flag
      flag_we = 1'b1; alu_zero = 1'b1;
      @(posedge clk); #1;                        // FETCH
      flag_we = 1'b0; alu_zero = 1'b0;
      check("rst_pre_zf", {63'd0, zero_flag}, {63'd0, 1'b1});
      instr_in = 24'h100001;
      @(posedge clk); #1;                        // DECODE
      @(posedge clk); #1;                        // EXEC
      stall = 1'b1;
      @(posedge clk); #1;                        // still EXEC
      check("rst_stalled_exec", {62'd0, phase}, {62'd0, 2'b10});
      begin
         int we_before;
         we_before = we_cnt;
         #2;
         reset = 1'b0;
         #1;
         check("rst_async_clear",
               {25'd0, phase, pc_enable, pc_branch, reg_we, halted, zero_flag, ir, branch_addr},
               {25'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, 8'h00});
         stall = 1'b0;
         @(posedge clk); #1;
         reset = 1'b1;
         #4;
         check("rst_release_fetch", {62'd0, phase}, {62'd0, 2'b00});
         check("rst_no_reg_we", 64'(we_cnt - we_before), 64'd0);
         @(posedge clk); #1;
         check("rst_then_decode", {38'd0, phase, ir}, {38'd0, 2'b01, 24'h100001});
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
